sha3_theta_elts_acc: RTL and testbench
======================================

Name: sha3_theta_elts_acc

Overview:
Parametrised theta-element evaluator for Keccak-f[25*LANE_W]. Accumulates the state's column parities over one or more input beats, then evaluates D[x] = C[x-1] ^ rotl(C[x+1],1). Adds valid/ready handshakes on both sides, plus abort. Sits between the round-state buffer and the theta-apply stage of the permutation core.

Parameters:
LANE_W, 64, lane width in bits; legal values 8, 16, 32, 64 (Keccak-f[200/400/800/1600]).
ROWS_PER_BEAT, 5, planes (y-rows) delivered per input beat; legal values 1 or 5; beats per state NBEATS = 5/ROWS_PER_BEAT.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous reset, active-low
ivalid  in  1  input beat valid
iready  out  1  block can accept a beat this cycle
irow  in  ROWS_PER_BEAT x 5 x LANE_W  lanes irow[r][x], rows in ascending y order
iabort  in  1  synchronous discard of a partially accumulated state
ovalid  out  1  oelt holds a valid result
oready  in  1  downstream accepts oelt
oelt  out  5 x LANE_W  theta elements D[0..4]

Behaviour:
- Reset (rst low, async): beat counter=0, acc=0, c_full=0, ovalid=0, oelt=0. iready reflects c_full=0 immediately.
- Accept: beat taken on an edge where ivalid && iready.
- Accumulation: beat parity P[x] = XOR over r of irow[r][x].
  - First beat (counter==0): acc[x] <= P[x].
  - Later beats: acc[x] <= acc[x] ^ P[x].
  - Counter increments per accepted beat and wraps to 0 on the last beat (NBEATS-1); that edge also sets c_full.
- Eval/move: c_move = c_full && (!ovalid || oready). On a c_move edge:
  - oelt[x] <= acc[(x+4)%5] ^ rotl(acc[(x+1)%5],1), where rotl rotates within LANE_W (bit LANE_W-1 -> bit 0).
  - ovalid <= 1; c_full <= 0 unless a new last beat is accepted on the same edge.
- Output drain: ovalid && oready with no c_move -> ovalid <= 0. oelt stays stable while ovalid && !oready.
- iready = !c_full || c_move, combinational. New first beat may overwrite acc on the same edge C moves out; the move uses the pre-edge acc.
- Latency: last beat accepted at edge k, no backpressure -> ovalid=1 and oelt valid after edge k+1.
  - Throughput: one state per NBEATS cycles, sustained.
- iabort (ivalid ignored that cycle): counter <= 0; partial acc discarded.
  - Does not clear c_full or ovalid; completed results are never dropped.
  - iabort with counter==0: no effect.
- With ROWS_PER_BEAT=5: counter is constant 0; every accepted beat is a last beat.
- Illegal parameter values: elaboration-time $error.

Optional Feature:
SHA3_THETA_PARITY_OUT_EN:
- Defined: adds output oparity (5 x LANE_W), the column parities C[x], registered alongside oelt on c_move, same ovalid, reset 0.
- Undefined: port and its registers are absent; behaviour otherwise identical.

Test Plan:
- All-zero state, LANE_W=64, ROWS_PER_BEAT=5 -> ovalid one edge after accept; all oelt = 0.
- Lane (x=1,y=0)=64'h1, rest 0 -> oelt[0]=64'h2, oelt[2]=64'h1, others 0. Same with LANE_W=8, lane=8'h80 -> oelt[0]=8'h01, oelt[2]=8'h80.
- ROWS_PER_BEAT=1, rows y=0..4 each with lane x=3 = 64'h1 -> C[3]=64'h1 (odd count); oelt[2]=64'h2, oelt[4]=64'h1. ovalid only after beat 5.
- Backpressure: oready=0 with two back-to-back states -> second state's C completes, iready=0, first oelt held stable. Raise oready -> second result follows next edge, no loss.
- ROWS_PER_BEAT=1: 3 beats then iabort, then a fresh 5-beat zero state -> oelt=0 (no residue); iabort while ovalid=1 leaves oelt intact.
- Assert rst low mid-accumulation (beat 2) and while ovalid=1 -> ovalid, oelt, counter 0 immediately; next full state produces correct result.

Source files
------------

// File: rtl/sha3_theta_elts_acc_if.sv
// Beat-in / theta-element-out handshake bundle for sha3_theta_elts_acc.
// The oparity member exists only when SHA3_THETA_PARITY_OUT_EN is defined.
interface sha3_theta_elts_acc_if #(
  parameter int LANE_W        = 64,
  parameter int ROWS_PER_BEAT = 5
);
  logic                                        ivalid;
  logic                                        iready;
  logic [ROWS_PER_BEAT-1:0][4:0][LANE_W-1:0]   irow;
  logic                                        iabort;
  logic                                        ovalid;
  logic                                        oready;
  logic [4:0][LANE_W-1:0]                      oelt;
`ifdef SHA3_THETA_PARITY_OUT_EN
  logic [4:0][LANE_W-1:0]                      oparity;

  modport master (output ivalid, irow, iabort, oready,
                  input  iready, ovalid, oelt, oparity);
  modport slave  (input  ivalid, irow, iabort, oready,
                  output iready, ovalid, oelt, oparity);
`else
  modport master (output ivalid, irow, iabort, oready,
                  input  iready, ovalid, oelt);
  modport slave  (input  ivalid, irow, iabort, oready,
                  output iready, ovalid, oelt);
`endif
endinterface

// File: rtl/sha3_theta_elts_acc.sv
// Keccak theta-element evaluator: accumulates column parities over NBEATS beats, emits D[x] one edge after
// the last beat; iready drops only while a finished C is blocked by a stalled output. Macro: SHA3_THETA_PARITY_OUT_EN.
module sha3_theta_elts_acc #(
  parameter int LANE_W        = 64,
  parameter int ROWS_PER_BEAT = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  sha3_theta_elts_acc_if.slave  bus
);

  localparam int         NBEATS    = 5 / ROWS_PER_BEAT;
  localparam logic [2:0] LAST_BEAT = 3'(NBEATS - 1);

  typedef logic [LANE_W-1:0] lane_t;
  typedef lane_t [4:0]       plane_t;

  generate
    if (!(LANE_W == 8 || LANE_W == 16 || LANE_W == 32 || LANE_W == 64)) begin : g_bad_lane_w
      $error("sha3_theta_elts_acc: LANE_W must be 8, 16, 32 or 64");
    end
    if (!(ROWS_PER_BEAT == 1 || ROWS_PER_BEAT == 5)) begin : g_bad_rows
      $error("sha3_theta_elts_acc: ROWS_PER_BEAT must be 1 or 5");
    end
  endgenerate

  function automatic lane_t rotl1(input lane_t a);
    return {a[LANE_W-2:0], a[LANE_W-1]};
  endfunction

  logic [2:0] cnt_q, cnt_d;
  plane_t     acc_q, acc_d;
  plane_t     oelt_q, oelt_d;
  logic       c_full_q, c_full_d;
  logic       ovalid_q, ovalid_d;
`ifdef SHA3_THETA_PARITY_OUT_EN
  plane_t     par_q, par_d;
`endif

  plane_t     beat_par;
  logic       take;
  logic       last;
  logic       c_move;
  logic       iready;

  always_comb begin
    beat_par = '0;
    for (int r = 0; r < ROWS_PER_BEAT; r++) begin
      for (int x = 0; x < 5; x++) begin
        beat_par[x] = beat_par[x] ^ bus.irow[r][x];
      end
    end
  end

  // The move reads pre-edge acc, so a new first beat may overwrite acc on the same edge.
  assign c_move = c_full_q && (!ovalid_q || bus.oready);
  assign iready = !c_full_q || c_move;
  assign take   = bus.ivalid && iready && !bus.iabort;
  assign last   = (cnt_q == LAST_BEAT);

  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    c_full_d = c_full_q;

    if (bus.iabort) begin
      cnt_d = '0;
    end else if (take) begin
      cnt_d = last ? 3'd0 : cnt_q + 3'd1;
      acc_d = (cnt_q == 3'd0) ? beat_par : (acc_q ^ beat_par);
    end

    if (take && last) begin
      c_full_d = 1'b1;
    end else if (c_move) begin
      c_full_d = 1'b0;
    end
  end

  always_comb begin
    oelt_d   = oelt_q;
    ovalid_d = ovalid_q;
`ifdef SHA3_THETA_PARITY_OUT_EN
    par_d    = par_q;
`endif
    if (c_move) begin
      for (int x = 0; x < 5; x++) begin
        oelt_d[x] = acc_q[(x + 4) % 5] ^ rotl1(acc_q[(x + 1) % 5]);
      end
      ovalid_d = 1'b1;
`ifdef SHA3_THETA_PARITY_OUT_EN
      par_d    = acc_q;
`endif
    end else if (bus.oready) begin
      ovalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      c_full_q <= 1'b0;
      ovalid_q <= 1'b0;
      oelt_q   <= '0;
`ifdef SHA3_THETA_PARITY_OUT_EN
      par_q    <= '0;
`endif
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      c_full_q <= c_full_d;
      ovalid_q <= ovalid_d;
      oelt_q   <= oelt_d;
`ifdef SHA3_THETA_PARITY_OUT_EN
      par_q    <= par_d;
`endif
    end
  end

  assign bus.iready = iready;
  assign bus.ovalid = ovalid_q;
  assign bus.oelt   = oelt_q;
`ifdef SHA3_THETA_PARITY_OUT_EN
  assign bus.oparity = par_q;
`endif

endmodule

// File: tb/tb_sha3_theta_elts_acc.sv
// Directed bench for sha3_theta_elts_acc: three instances (64-bit/5 rows, 8-bit/5 rows, 64-bit/1 row).
module tb_sha3_theta_elts_acc;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  sha3_theta_elts_acc_if #(.LANE_W(64), .ROWS_PER_BEAT(5)) if_a ();
  sha3_theta_elts_acc_if #(.LANE_W(8),  .ROWS_PER_BEAT(5)) if_b ();
  sha3_theta_elts_acc_if #(.LANE_W(64), .ROWS_PER_BEAT(1)) if_c ();

  sha3_theta_elts_acc #(.LANE_W(64), .ROWS_PER_BEAT(5)) u_a (.clk(clk), .rst(rst), .bus(if_a));
  sha3_theta_elts_acc #(.LANE_W(8),  .ROWS_PER_BEAT(5)) u_b (.clk(clk), .rst(rst), .bus(if_b));
  sha3_theta_elts_acc #(.LANE_W(64), .ROWS_PER_BEAT(1)) u_c (.clk(clk), .rst(rst), .bus(if_c));

  logic [4:0][63:0] e1, e2, erot, ezero;
  logic [4:0][7:0]  e8;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    if_a.ivalid = 0; if_a.iabort = 0; if_a.oready = 1; if_a.irow = '0;
    if_b.ivalid = 0; if_b.iabort = 0; if_b.oready = 1; if_b.irow = '0;
    if_c.ivalid = 0; if_c.iabort = 0; if_c.oready = 1; if_c.irow = '0;
    rst = 0;
    #3;
    checks++; if (if_a.ovalid !== 1'b0 || if_a.oelt !== ezero || if_a.iready !== 1'b1) begin
      failures++; $display("FAIL reset_a ovalid=%b iready=%b oelt=%h", if_a.ovalid, if_a.iready, if_a.oelt);
    end
    checks++; if (if_b.ovalid !== 1'b0 || if_b.oelt !== 40'h0 || if_b.iready !== 1'b1) begin
      failures++; $display("FAIL reset_b ovalid=%b iready=%b oelt=%h", if_b.ovalid, if_b.iready, if_b.oelt);
    end
    checks++; if (if_c.ovalid !== 1'b0 || if_c.oelt !== ezero || if_c.iready !== 1'b1) begin
      failures++; $display("FAIL reset_c ovalid=%b iready=%b oelt=%h", if_c.ovalid, if_c.iready, if_c.oelt);
    end
    tick(); tick();
    rst = 1;
    tick();
  endtask

  task automatic test_zero_state();
    if_a.irow = '0; if_a.ivalid = 1;
    tick();
    if_a.ivalid = 0;
    checks++; if (if_a.ovalid !== 1'b0) begin
      failures++; $display("FAIL zero_latency_early ovalid=%b want 0", if_a.ovalid);
    end
    tick();
    checks++; if (if_a.ovalid !== 1'b1 || if_a.oelt !== ezero) begin
      failures++; $display("FAIL zero_state ovalid=%b oelt=%h want 1/0", if_a.ovalid, if_a.oelt);
    end
    tick();
    checks++; if (if_a.ovalid !== 1'b0) begin
      failures++; $display("FAIL zero_drain ovalid=%b want 0", if_a.ovalid);
    end
  endtask

  task automatic test_single_lane();
    if_a.irow = '0; if_a.irow[0][1] = 64'h1; if_a.ivalid = 1;
    if_b.irow = '0; if_b.irow[0][1] = 8'h80;  if_b.ivalid = 1;
    tick();
    if_a.ivalid = 0; if_b.ivalid = 0;
    tick();
    checks++; if (if_a.ovalid !== 1'b1 || if_a.oelt !== e1) begin
      failures++; $display("FAIL lane64 ovalid=%b oelt=%h want %h", if_a.ovalid, if_a.oelt, e1);
    end
    checks++; if (if_b.ovalid !== 1'b1 || if_b.oelt !== e8) begin
      failures++; $display("FAIL lane8 ovalid=%b oelt=%h want %h", if_b.ovalid, if_b.oelt, e8);
    end
    // XOR across rows plus rotate wrap of the top bit
    if_a.irow = '0; if_a.irow[2][0] = 64'h8000_0000_0000_0001; if_a.irow[3][0] = 64'h1; if_a.ivalid = 1;
    tick();
    if_a.ivalid = 0;
    tick();
    checks++; if (if_a.oelt !== erot) begin
      failures++; $display("FAIL rot_wrap oelt=%h want %h", if_a.oelt, erot);
    end
    tick();
  endtask

  task automatic test_rows1();
    if_c.oready = 1;
    for (int b = 0; b < 5; b++) begin
      if_c.irow = '0; if_c.irow[0][3] = 64'h1; if_c.ivalid = 1;
      tick();
      checks++; if (if_c.ovalid !== 1'b0) begin
        failures++; $display("FAIL rows1_early beat=%0d ovalid=%b want 0", b, if_c.ovalid);
      end
    end
    if_c.ivalid = 0;
    tick();
    checks++; if (if_c.ovalid !== 1'b1 || if_c.oelt !== e2) begin
      failures++; $display("FAIL rows1_result ovalid=%b oelt=%h want %h", if_c.ovalid, if_c.oelt, e2);
    end
    tick();
  endtask

  task automatic test_backpressure();
    if_a.oready = 0;
    if_a.irow = '0; if_a.irow[0][1] = 64'h1; if_a.ivalid = 1;
    tick();
    if_a.irow = '0; if_a.irow[0][3] = 64'h1;
    tick();
    if_a.ivalid = 0;
    for (int k = 0; k < 2; k++) begin
      checks++; if (if_a.iready !== 1'b0 || if_a.ovalid !== 1'b1 || if_a.oelt !== e1) begin
        failures++; $display("FAIL bp_hold k=%0d iready=%b ovalid=%b oelt=%h", k, if_a.iready, if_a.ovalid, if_a.oelt);
      end
      tick();
    end
    if_a.oready = 1;
    #1;
    checks++; if (if_a.iready !== 1'b1) begin
      failures++; $display("FAIL bp_iready_release iready=%b want 1", if_a.iready);
    end
    tick();
    checks++; if (if_a.ovalid !== 1'b1 || if_a.oelt !== e2) begin
      failures++; $display("FAIL bp_second ovalid=%b oelt=%h want %h", if_a.ovalid, if_a.oelt, e2);
    end
    tick();
    checks++; if (if_a.ovalid !== 1'b0) begin
      failures++; $display("FAIL bp_drain ovalid=%b want 0", if_a.ovalid);
    end
  endtask

  task automatic test_abort();
    if_c.oready = 0;
    for (int b = 0; b < 5; b++) begin
      if_c.irow = '0; if_c.irow[0][3] = 64'h1; if_c.ivalid = 1;
      tick();
    end
    for (int b = 0; b < 3; b++) begin
      if_c.irow = '0; if_c.irow[0][0] = 64'hFF; if_c.ivalid = 1;
      tick();
    end
    if_c.iabort = 1;
    tick();
    if_c.iabort = 0; if_c.ivalid = 0;
    checks++; if (if_c.ovalid !== 1'b1 || if_c.oelt !== e2) begin
      failures++; $display("FAIL abort_keeps_result ovalid=%b oelt=%h want %h", if_c.ovalid, if_c.oelt, e2);
    end
    if_c.oready = 1;
    tick();
    for (int b = 0; b < 5; b++) begin
      if_c.irow = '0; if_c.ivalid = 1;
      tick();
      checks++; if (if_c.ovalid !== 1'b0) begin
        failures++; $display("FAIL abort_early beat=%0d ovalid=%b want 0", b, if_c.ovalid);
      end
    end
    if_c.ivalid = 0;
    tick();
    checks++; if (if_c.ovalid !== 1'b1 || if_c.oelt !== ezero) begin
      failures++; $display("FAIL abort_residue ovalid=%b oelt=%h want 0", if_c.ovalid, if_c.oelt);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    for (int b = 0; b < 2; b++) begin
      if_c.irow = '0; if_c.irow[0][0] = 64'hFF; if_c.ivalid = 1;
      tick();
    end
    if_c.ivalid = 0;
    rst = 0;
    #1;
    checks++; if (if_c.ovalid !== 1'b0 || if_c.iready !== 1'b1 || if_c.oelt !== ezero) begin
      failures++; $display("FAIL rst_mid ovalid=%b iready=%b oelt=%h", if_c.ovalid, if_c.iready, if_c.oelt);
    end
    tick();
    rst = 1;
    for (int b = 0; b < 5; b++) begin
      if_c.irow = '0; if_c.irow[0][3] = 64'h1; if_c.ivalid = 1;
      tick();
      checks++; if (if_c.ovalid !== 1'b0) begin
        failures++; $display("FAIL rst_mid_early beat=%0d ovalid=%b want 0", b, if_c.ovalid);
      end
    end
    if_c.ivalid = 0;
    tick();
    checks++; if (if_c.ovalid !== 1'b1 || if_c.oelt !== e2) begin
      failures++; $display("FAIL rst_mid_result ovalid=%b oelt=%h want %h", if_c.ovalid, if_c.oelt, e2);
    end
    tick();
    // reset while a result is held
    if_a.oready = 0;
    if_a.irow = '0; if_a.irow[0][1] = 64'h1; if_a.ivalid = 1;
    tick();
    if_a.ivalid = 0;
    tick();
    rst = 0;
    #1;
    checks++; if (if_a.ovalid !== 1'b0 || if_a.oelt !== ezero) begin
      failures++; $display("FAIL rst_held ovalid=%b oelt=%h want 0/0", if_a.ovalid, if_a.oelt);
    end
    tick();
    rst = 1;
    if_a.oready = 1;
    tick();
  endtask

  task automatic test_back_to_back();
    if_a.oready = 1;
    if_a.irow = '0; if_a.irow[0][1] = 64'h1; if_a.ivalid = 1;
    tick();
    if_a.irow = '0; if_a.irow[0][3] = 64'h1;
    tick();
    checks++; if (if_a.ovalid !== 1'b1 || if_a.oelt !== e1 || if_a.iready !== 1'b1) begin
      failures++; $display("FAIL b2b_first ovalid=%b iready=%b oelt=%h", if_a.ovalid, if_a.iready, if_a.oelt);
    end
    if_a.irow = '0;
    tick();
    checks++; if (if_a.ovalid !== 1'b1 || if_a.oelt !== e2) begin
      failures++; $display("FAIL b2b_second ovalid=%b oelt=%h want %h", if_a.ovalid, if_a.oelt, e2);
    end
    if_a.ivalid = 0;
    tick();
    checks++; if (if_a.ovalid !== 1'b1 || if_a.oelt !== ezero) begin
      failures++; $display("FAIL b2b_third ovalid=%b oelt=%h want 0", if_a.ovalid, if_a.oelt);
    end
    tick();
    checks++; if (if_a.ovalid !== 1'b0) begin
      failures++; $display("FAIL b2b_drain ovalid=%b want 0", if_a.ovalid);
    end
  endtask

  initial begin
    ezero = '0;
    e1 = '0;   e1[0] = 64'h2;   e1[2] = 64'h1;
    e2 = '0;   e2[2] = 64'h2;   e2[4] = 64'h1;
    erot = '0; erot[1] = 64'h8000_0000_0000_0000; erot[4] = 64'h1;
    e8 = '0;   e8[0] = 8'h01;   e8[2] = 8'h80;

    test_reset();
    test_zero_state();
    test_single_lane();
    test_rows1();
    test_backpressure();
    test_abort();
    test_reset_mid();
    test_back_to_back();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
